// File: rtl/rom_player_if.sv
`default_nettype none
//==============================================================================
// Module   : rom_player_if
// Brief    : AXI-Stream bundle carrying rom_player output beats downstream.
// Revision : 1.0
//==============================================================================
interface rom_player_if #(
    parameter int AXIS_DATA_WIDTH  = 512,
    parameter int AXIS_TUSER_WIDTH = 256
);
    logic [AXIS_DATA_WIDTH-1:0]   tdata;
    logic [AXIS_DATA_WIDTH/8-1:0] tkeep;
    logic [AXIS_TUSER_WIDTH-1:0]  tuser;
    logic                         tvalid;
    logic                         tready;
    logic                         tlast;

    modport master (output tdata, tkeep, tuser, tvalid, tlast, input tready);
    modport slave  (input tdata, tkeep, tuser, tvalid, tlast, output tready);
endinterface
`default_nettype wire

// File: rtl/rom_player.sv
`default_nettype none
//==============================================================================
// Module   : rom_player
// Brief    : Replays an address range of a registered beat ROM onto AXI-Stream,
//            with repeat count, gap dropping and packet-aligned stop.
// Revision : 1.0
//==============================================================================
module rom_player #(
    parameter int AXIS_DATA_WIDTH  = 512,
    parameter int AXIS_TUSER_WIDTH = 256,
    parameter int ADDR_WIDTH       = 12,
    parameter int LOOP_WIDTH       = 16
) (
    input  wire                          clk,
    input  wire                          rst,
    input  wire                          start,
    input  wire                          stop,
    input  wire [ADDR_WIDTH-1:0]         cfg_start_addr,
    input  wire [ADDR_WIDTH-1:0]         cfg_end_addr,
    input  wire [LOOP_WIDTH-1:0]         cfg_loops,
    output logic [ADDR_WIDTH-1:0]        rom_addr,
    input  wire [AXIS_DATA_WIDTH-1:0]    rom_tdata,
    input  wire [AXIS_DATA_WIDTH/8-1:0]  rom_tkeep,
    input  wire [AXIS_TUSER_WIDTH-1:0]   rom_tuser,
    input  wire                          rom_tvalid,
    input  wire                          rom_tlast,
    rom_player_if.master                 m_axis,
    output logic                         busy,
    output logic                         done,
    output logic [31:0]                  beat_count
);
    localparam int c_KEEP_W  = AXIS_DATA_WIDTH / 8;
    localparam int c_ENTRY_W = AXIS_DATA_WIDTH + c_KEEP_W + AXIS_TUSER_WIDTH + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   start_addr_q, start_addr_d;
    logic [ADDR_WIDTH-1:0]   end_addr_q, end_addr_d;
    logic [LOOP_WIDTH-1:0]   loops_q, loops_d;
    logic [ADDR_WIDTH-1:0]   rom_addr_q, rom_addr_d;
    logic [LOOP_WIDTH-1:0]   pass_q, pass_d;
    logic                    inflight_q, inflight_d;
    logic                    stop_pend_q, stop_pend_d;
    logic                    drop_q, drop_d;
    logic                    done_q, done_d;
    logic [31:0]             beat_count_q, beat_count_d;
    logic [1:0]              count_q, count_d;
    logic [c_ENTRY_W-1:0]    slot0_q, slot1_q;

    logic                    w_pop;
    logic                    w_push;
    logic [2:0]              w_occ;
    logic                    w_issue;
    logic                    w_at_end;
    logic [LOOP_WIDTH-1:0]   w_pass_inc;
    logic                    w_limit;
    logic                    w_halt;
    logic [c_ENTRY_W-1:0]    w_entry;

    assign w_pop      = m_axis.tvalid & m_axis.tready;
    assign w_push     = inflight_q & rom_tvalid & ~drop_q;
    // Reads in flight count against the 2-entry FIFO so a result always has a slot.
    assign w_occ      = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, w_pop};
    assign w_issue    = (state_q == S_RUN) && (w_occ < 3'd2);
    assign w_at_end   = (rom_addr_q == end_addr_q);
    assign w_pass_inc = pass_q + 1'b1;
    assign w_limit    = w_issue && w_at_end && (loops_q != '0) && (w_pass_inc == loops_q);
    assign w_halt     = (state_q == S_RUN) && stop_pend_q && w_push && rom_tlast;
    assign w_entry    = {rom_tlast, rom_tuser, rom_tkeep, rom_tdata};

    always_comb begin
        count_d = count_q;
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        start_addr_d = start_addr_q;
        end_addr_d   = end_addr_q;
        loops_d      = loops_q;
        rom_addr_d   = rom_addr_q;
        pass_d       = pass_q;
        inflight_d   = 1'b0;
        stop_pend_d  = stop_pend_q;
        drop_d       = drop_q;
        done_d       = 1'b0;
        beat_count_d = beat_count_q;

        if (w_pop && (beat_count_q != 32'hFFFF_FFFF)) begin
            beat_count_d = beat_count_q + 32'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d      = S_RUN;
                    start_addr_d = cfg_start_addr;
                    end_addr_d   = cfg_end_addr;
                    loops_d      = cfg_loops;
                    rom_addr_d   = cfg_start_addr;
                    pass_d       = '0;
                    stop_pend_d  = 1'b0;
                    drop_d       = 1'b0;
                    beat_count_d = '0;
                end
            end
            S_RUN: begin
                if (stop) begin
                    stop_pend_d = 1'b1;
                end
                if (w_issue) begin
                    inflight_d = 1'b1;
                    if (w_at_end) begin
                        rom_addr_d = start_addr_q;
                        pass_d     = w_pass_inc;
                    end else begin
                        rom_addr_d = rom_addr_q + 1'b1;
                    end
                end
                // Loop limit wins over a pending stop; a stop halt drops the read issued alongside it.
                if (w_limit) begin
                    state_d = S_DRAIN;
                end else if (w_halt) begin
                    state_d = S_DRAIN;
                    drop_d  = w_issue;
                end
            end
            S_DRAIN: begin
                if (count_d == 2'd0) begin
                    state_d     = S_IDLE;
                    done_d      = 1'b1;
                    drop_d      = 1'b0;
                    stop_pend_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            start_addr_q <= '0;
            end_addr_q   <= '0;
            loops_q      <= '0;
            rom_addr_q   <= '0;
            pass_q       <= '0;
            inflight_q   <= 1'b0;
            stop_pend_q  <= 1'b0;
            drop_q       <= 1'b0;
            done_q       <= 1'b0;
            beat_count_q <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            start_addr_q <= start_addr_d;
            end_addr_q   <= end_addr_d;
            loops_q      <= loops_d;
            rom_addr_q   <= rom_addr_d;
            pass_q       <= pass_d;
            inflight_q   <= inflight_d;
            stop_pend_q  <= stop_pend_d;
            drop_q       <= drop_d;
            done_q       <= done_d;
            beat_count_q <= beat_count_d;
            count_q      <= count_d;
        end
    end

    // Head slot only changes on a pop or when filling an empty FIFO, keeping outputs stable under stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot0_q <= '0;
            slot1_q <= '0;
        end else if (w_pop) begin
            if (w_push && (count_q == 2'd1)) begin
                slot0_q <= w_entry;
            end else if (count_q == 2'd2) begin
                slot0_q <= slot1_q;
            end
            if (w_push && (count_q == 2'd2)) begin
                slot1_q <= w_entry;
            end
        end else if (w_push) begin
            if (count_q == 2'd0) begin
                slot0_q <= w_entry;
            end else begin
                slot1_q <= w_entry;
            end
        end
    end

    assign m_axis.tdata  = slot0_q[AXIS_DATA_WIDTH-1:0];
    assign m_axis.tkeep  = slot0_q[AXIS_DATA_WIDTH +: c_KEEP_W];
    assign m_axis.tuser  = slot0_q[AXIS_DATA_WIDTH+c_KEEP_W +: AXIS_TUSER_WIDTH];
    assign m_axis.tlast  = slot0_q[c_ENTRY_W-1];
    assign m_axis.tvalid = (count_q != 2'd0);

    assign rom_addr   = rom_addr_q;
    assign busy       = (state_q != S_IDLE);
    assign done       = done_q;
    assign beat_count = beat_count_q;
endmodule
`default_nettype wire

// File: tb/tb_rom_player.sv
`default_nettype none
//==============================================================================
// Module   : tb_rom_player
// Brief    : Directed self-checking bench for rom_player with a registered ROM model.
// Revision : 1.0
//==============================================================================
module tb_rom_player;
    localparam int DW = 32;
    localparam int UW = 8;
    localparam int AW = 12;
    localparam int LW = 16;

    logic clk = 1'b0;
    logic rst;
    logic start, stop;
    logic [AW-1:0]   cfg_start_addr, cfg_end_addr;
    logic [LW-1:0]   cfg_loops;
    logic [AW-1:0]   rom_addr;
    logic [DW-1:0]   rom_tdata;
    logic [DW/8-1:0] rom_tkeep;
    logic [UW-1:0]   rom_tuser;
    logic            rom_tvalid, rom_tlast;
    logic            busy, done;
    logic [31:0]     beat_count;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int viol = 0;
    logic        prev_stall = 1'b0;
    logic [63:0] prev_out = '0;
    logic [63:0] beats[$];
    int          pop_cyc[$];
    logic [63:0] exp_q[$];
    logic        mem_v [0:4095];
    logic        mem_l [0:4095];

    always #5 clk = ~clk;

    rom_player_if #(.AXIS_DATA_WIDTH(DW), .AXIS_TUSER_WIDTH(UW)) m_axis ();

    rom_player #(
        .AXIS_DATA_WIDTH(DW), .AXIS_TUSER_WIDTH(UW), .ADDR_WIDTH(AW), .LOOP_WIDTH(LW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .cfg_start_addr(cfg_start_addr), .cfg_end_addr(cfg_end_addr), .cfg_loops(cfg_loops),
        .rom_addr(rom_addr), .rom_tdata(rom_tdata), .rom_tkeep(rom_tkeep),
        .rom_tuser(rom_tuser), .rom_tvalid(rom_tvalid), .rom_tlast(rom_tlast),
        .m_axis(m_axis), .busy(busy), .done(done), .beat_count(beat_count)
    );

    function automatic logic [63:0] exp_beat(input logic [11:0] a, input logic l);
        return {19'd0, l, a[7:0] ^ 8'h5A, a[3:0], 20'hABCDE, a};
    endfunction

    // Registered ROM: data appears one cycle after the address
    always @(posedge clk) begin
        rom_tdata  <= {20'hABCDE, rom_addr};
        rom_tkeep  <= rom_addr[3:0];
        rom_tuser  <= rom_addr[7:0] ^ 8'h5A;
        rom_tvalid <= mem_v[rom_addr];
        rom_tlast  <= mem_l[rom_addr];
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin : monitor
        logic [63:0] cur;
        cur = {19'd0, m_axis.tlast, m_axis.tuser, m_axis.tkeep, m_axis.tdata};
        if (prev_stall && !rst && (!m_axis.tvalid || cur !== prev_out)) viol <= viol + 1;
        if (m_axis.tvalid && m_axis.tready) begin
            beats.push_back(cur);
            pop_cyc.push_back(cyc);
        end
        if (done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
        prev_stall <= m_axis.tvalid && !m_axis.tready && !rst;
        prev_out   <= cur;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 4096; i++) begin
            mem_v[i] = 1'b1;
            mem_l[i] = 1'b0;
        end
    endtask

    task automatic do_start(input logic [AW-1:0] sa, input logic [AW-1:0] ea, input logic [LW-1:0] lp);
        beats.delete();
        pop_cyc.delete();
        exp_q.delete();
        cfg_start_addr = sa;
        cfg_end_addr   = ea;
        cfg_loops      = lp;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int maxc, input bit toggle, input string tag);
        int d0;
        int n;
        d0 = done_cnt;
        n = 0;
        while (done_cnt == d0 && n < maxc) begin
            if (toggle) m_axis.tready = ((n % 4) == 0) || ((n % 4) == 3);
            tick();
            n++;
        end
        m_axis.tready = 1'b1;
        check({tag, " done seen"}, 64'(done_cnt != d0), 64'd1);
    endtask

    task automatic compare_beats(input string tag);
        check({tag, " beat count"}, 64'(beats.size()), 64'(exp_q.size()));
        foreach (exp_q[i]) begin
            check($sformatf("%s beat%0d", tag, i),
                  (i < beats.size()) ? beats[i] : 64'hFFFF_FFFF_FFFF_FFFF, exp_q[i]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int d0;
        int n;
        rst = 1'b1; start = 1'b0; stop = 1'b0;
        cfg_start_addr = '0; cfg_end_addr = '0; cfg_loops = '0;
        m_axis.tready = 1'b1;
        clear_rom();
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Reset state
        check("rst tvalid", 64'(m_axis.tvalid), 64'd0);
        check("rst tlast", 64'(m_axis.tlast), 64'd0);
        check("rst tdata", 64'(m_axis.tdata), 64'd0);
        check("rst busy", 64'(busy), 64'd0);
        check("rst done", 64'(done), 64'd0);
        check("rst beat_count", 64'(beat_count), 64'd0);
        check("rst rom_addr", 64'(rom_addr), 64'd0);

        // Range 0..3, single pass, full throughput
        mem_l[3] = 1'b1;
        do_start(12'h000, 12'h003, 16'd1);
        check("t1 busy", 64'(busy), 64'd1);
        check("t1 addr", 64'(rom_addr), 64'd0);
        check("t1 tvalid c1", 64'(m_axis.tvalid), 64'd0);
        tick();
        check("t1 tvalid c2", 64'(m_axis.tvalid), 64'd0);
        tick();
        check("t1 tvalid c3", 64'(m_axis.tvalid), 64'd1);
        check("t1 first tdata", 64'(m_axis.tdata), 64'h0000_0000_ABCD_E000);
        d0 = done_cnt;
        wait_done(50, 1'b0, "t1");
        for (int a = 0; a < 4; a++) exp_q.push_back(exp_beat(12'(a), a == 3));
        compare_beats("t1");
        if (pop_cyc.size() == 4) begin
            check("t1 consecutive", 64'(pop_cyc[3] - pop_cyc[0]), 64'd3);
            check("t1 done timing", 64'(done_cyc), 64'(pop_cyc[3] + 1));
        end else begin
            check("t1 pop count", 64'(pop_cyc.size()), 64'd4);
        end
        check("t1 beat_count", 64'(beat_count), 64'd4);
        tick();
        check("t1 done pulses", 64'(done_cnt - d0), 64'd1);
        check("t1 done low", 64'(done), 64'd0);
        check("t1 busy low", 64'(busy), 64'd0);

        // Three passes under a 1,0,0,1 tready pattern
        do_start(12'h000, 12'h003, 16'd3);
        wait_done(200, 1'b1, "t2");
        for (int p = 0; p < 3; p++)
            for (int a = 0; a < 4; a++) exp_q.push_back(exp_beat(12'(a), a == 3));
        compare_beats("t2");
        check("t2 stability", 64'(viol), 64'd0);
        check("t2 beat_count", 64'(beat_count), 64'd12);

        // Gap entries 5 and 6 are dropped
        clear_rom();
        mem_v[5] = 1'b0; mem_v[6] = 1'b0; mem_l[8] = 1'b1;
        do_start(12'h004, 12'h008, 16'd1);
        wait_done(50, 1'b0, "t3");
        exp_q.push_back(exp_beat(12'h004, 1'b0));
        exp_q.push_back(exp_beat(12'h007, 1'b0));
        exp_q.push_back(exp_beat(12'h008, 1'b1));
        compare_beats("t3");
        check("t3 beat_count", 64'(beat_count), 64'd3);

        // Range wrapping through the top address
        clear_rom();
        mem_l[1] = 1'b1;
        do_start(12'hFFE, 12'h001, 16'd1);
        wait_done(50, 1'b0, "t4");
        exp_q.push_back(exp_beat(12'hFFE, 1'b0));
        exp_q.push_back(exp_beat(12'hFFF, 1'b0));
        exp_q.push_back(exp_beat(12'h000, 1'b0));
        exp_q.push_back(exp_beat(12'h001, 1'b1));
        compare_beats("t4");
        check("t4 beat_count", 64'(beat_count), 64'd4);

        // Infinite loop, stop during first beat of pass 2
        clear_rom();
        mem_l[2] = 1'b1;
        do_start(12'h000, 12'h002, 16'd0);
        n = 0;
        while (beats.size() < 3 && n < 50) begin
            tick();
            n++;
        end
        check("t5 pass2 head", 64'(m_axis.tdata), 64'h0000_0000_ABCD_E000);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        wait_done(50, 1'b0, "t5");
        for (int p = 0; p < 2; p++)
            for (int a = 0; a < 3; a++) exp_q.push_back(exp_beat(12'(a), a == 2));
        compare_beats("t5");
        check("t5 beat_count", 64'(beat_count), 64'd6);
        check("t5 busy", 64'(busy), 64'd0);

        // Reset while the FIFO is full and stalled
        clear_rom();
        m_axis.tready = 1'b0;
        do_start(12'h000, 12'h007, 16'd1);
        repeat (6) tick();
        check("t6 stalled tvalid", 64'(m_axis.tvalid), 64'd1);
        check("t6 stalled tdata", 64'(m_axis.tdata), 64'h0000_0000_ABCD_E000);
        rst = 1'b1;
        tick();
        check("t6 rst tvalid", 64'(m_axis.tvalid), 64'd0);
        check("t6 rst busy", 64'(busy), 64'd0);
        check("t6 rst rom_addr", 64'(rom_addr), 64'd0);
        check("t6 rst tdata", 64'(m_axis.tdata), 64'd0);
        rst = 1'b0;
        m_axis.tready = 1'b1;
        tick();
        do_start(12'h002, 12'h003, 16'd1);
        wait_done(50, 1'b0, "t6");
        exp_q.push_back(exp_beat(12'h002, 1'b0));
        exp_q.push_back(exp_beat(12'h003, 1'b0));
        compare_beats("t6");
        check("t6 beat_count", 64'(beat_count), 64'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/rom_player.md
Name: rom_player

Overview:
- Sequencer for the registered AXIS beat ROM (1-cycle read latency, no backpressure input).
- Drives the ROM address over a configured inclusive range, repeats it a configured number of times, and presents the beats on an AXIS master with full tready backpressure.
- ROM entries with tvalid=0 are gaps and are dropped.
- Sits between the ROM and the downstream packet pipeline as the traffic-replay source.

Parameters:
AXIS_DATA_WIDTH, 512, tdata width
AXIS_TUSER_WIDTH, 256, tuser width
ADDR_WIDTH, 12, ROM address width
LOOP_WIDTH, 16, width of repeat count

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
start  in  1  pulse; begin playback (ignored while busy)
stop  in  1  pulse; end playback at next packet boundary
cfg_start_addr  in  ADDR_WIDTH  first ROM entry, sampled on accepted start
cfg_end_addr  in  ADDR_WIDTH  last ROM entry (inclusive), sampled on accepted start
cfg_loops  in  LOOP_WIDTH  passes over range; 0 = infinite; sampled on accepted start
rom_addr  out  ADDR_WIDTH  ROM read address
rom_tdata  in  AXIS_DATA_WIDTH  ROM data, valid 1 cycle after rom_addr
rom_tkeep  in  AXIS_DATA_WIDTH/8  ROM keep
rom_tuser  in  AXIS_TUSER_WIDTH  ROM user
rom_tvalid  in  1  ROM entry-present flag
rom_tlast  in  1  ROM last flag
m_axis_tdata  out  AXIS_DATA_WIDTH  output stream data
m_axis_tkeep  out  AXIS_DATA_WIDTH/8  output keep
m_axis_tuser  out  AXIS_TUSER_WIDTH  output user
m_axis_tvalid  out  1  output valid
m_axis_tready  in  1  downstream ready
m_axis_tlast  out  1  output last
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse on return to IDLE
beat_count  out  32  beats accepted downstream since last start

Behaviour:
- Reset: state IDLE; rom_addr=0; m_axis_tvalid=0; m_axis_tlast/tdata/tkeep/tuser=0; busy=0; done=0; beat_count=0; buffer empty; in-flight flag cleared. Applies mid-playback; all buffered beats are discarded.
- States: IDLE, RUN, DRAIN.
- IDLE: start=1 -> latch cfg, beat_count<=0, rom_addr<=cfg_start_addr, go to RUN, busy=1 next cycle.
- Issue: in RUN, one address per cycle when (buffer_count + inflight - pop) < 2, where pop = m_axis_tvalid & m_axis_tready. An issued read sets inflight; its result is captured the next cycle.
- Captured entry with rom_tvalid=0: discarded. Otherwise it is pushed to a 2-entry FIFO whose head drives m_axis_*.
- Throughput: one beat per cycle sustained when tready=1 and all entries are valid. First beat appears 2 cycles after start (issue cycle, then capture cycle).
- AXIS rule: once m_axis_tvalid=1, all m_axis_* outputs stay stable until tready=1. m_axis_tvalid never depends combinationally on tready.
- Address advance:
  - After issuing cfg_end_addr, rom_addr wraps to cfg_start_addr and the pass counter increments.
  - Range is modular: length = (end - start) mod 2^ADDR_WIDTH + 1. end<start wraps through the top address. end==start gives a single entry.
- When the pass counter reaches cfg_loops (cfg_loops != 0): stop issuing, go to DRAIN. cfg_loops=0 runs until stop.
- Stop:
  - stop=1 in RUN arms stop_pending.
  - Issuing continues until a captured entry with rom_tvalid&rom_tlast is pushed. Then issuing halts; the one in-flight result after it is discarded; go to DRAIN.
  - If stop is pending when the loop limit is hit, loop-limit behaviour applies.
  - stop in IDLE or DRAIN is ignored.
  - start and stop asserted together in IDLE: start accepted, stop ignored.
- DRAIN: no issue. Exit when the FIFO is empty and nothing is in flight. On exit: done=1 for one cycle, busy=0, state IDLE.
- beat_count increments on each pop and saturates at 2^32-1.

Test Plan:
- Range 0..3 with all valid, tlast at 3; cfg_loops=1; tready=1 -> 4 beats on consecutive cycles, first 2 cycles after start, tlast on beat 4, done 1 cycle after last pop, beat_count=4.
- Same range, cfg_loops=3; tready toggled 1,0,0,1 pattern -> 12 beats in exact order 0,1,2,3 x3; no beat lost or duplicated; outputs held stable while tready=0.
- Entries 5 and 6 have tvalid=0 in range 4..8 -> only 4,7,8 delivered, beat_count=3.
- cfg_start_addr=0xFFE, cfg_end_addr=0x001 -> order FFE, FFF, 000, 001.
- cfg_loops=0, packet of 3 beats (tlast at entry 2), stop asserted during beat 1 of pass 2 -> output ends on the tlast of that packet, then done pulse.
- rst asserted while FIFO is full and tready=0 -> next cycle m_axis_tvalid=0, busy=0, state IDLE; new start plays from cfg_start_addr.
